// File: rtl/boot_loader_pkg.sv
// Shared definitions for the byte-serial program loader: framing constants and FSM states.
package boot_loader_pkg;

    // Width of the big-endian word-count header; fixed by the frame format.
    localparam int unsigned CNT_WIDTH = 16;

    // Bytes per instruction word.
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        StCntHi = 3'd0,
        StCntLo = 3'd1,
        StData  = 3'd2,
        StCsum  = 3'd3,
        StRun   = 3'd4,
        StError = 3'd5
    } state_e;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Assembles big-endian 32-bit words from data bytes and keeps the running XOR checksum.
module boot_loader_word_assembler
    import boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum
);

    // Only the first three bytes of a word need storing; the fourth is taken straight
    // from i_byte so the complete word is available in the cycle of its last handshake.
    logic [23:0] r_shift;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_csum;

    // Shift each data byte in MSB-first, advance the byte position and fold into the checksum
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
        end else if (i_valid) begin
            r_shift    <= {r_shift[15:0], i_byte};
            r_byte_idx <= r_byte_idx + 2'd1;
            r_csum     <= r_csum ^ i_byte;
        end
    end

    assign o_word_done = i_valid && (r_byte_idx == 2'(WORD_BYTES - 1));
    assign o_word      = {r_shift, i_byte};
    assign o_csum      = r_csum;

endmodule

// File: rtl/boot_loader.sv
// Framed program loader: writes a byte-streamed image into instruction memory, then releases
// the core from reset once the trailing XOR checksum matches.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_nrst,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

    state_e               r_state;
    logic [CNT_WIDTH-1:0] r_count;
    logic [IDX_W-1:0]     r_word_idx;
    logic                 r_rx_ready;
    logic                 r_imem_we;
    logic [31:0]          r_imem_addr;
    logic [31:0]          r_imem_wdata;
    logic                 r_cpu_nrst;
    logic                 r_done;
    logic                 r_err;

    logic                 w_xfer;
    logic                 w_asm_valid;
    logic                 w_word_done;
    logic [31:0]          w_word;
    logic [7:0]           w_csum;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 w_last_word;

    assign w_xfer       = rx_valid && r_rx_ready;
    assign w_asm_valid  = w_xfer && (r_state == StData);
    assign w_count_next = {r_count[CNT_WIDTH-1:8], rx_data};
    assign w_last_word  = ((32'(r_word_idx) + 32'd1) == 32'(r_count));

    boot_loader_word_assembler u_word_asm (
        .i_clk       (clk),
        .i_rst       (nrst),
        .i_valid     (w_asm_valid),
        .i_byte      (rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_csum      (w_csum)
    );

    // Frame FSM with registered handshake, write-port and core-reset outputs
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state      <= StCntHi;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_nrst   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                StCntHi: begin
                    if (w_xfer) begin
                        r_count[CNT_WIDTH-1:8] <= rx_data;
                        r_state                <= StCntLo;
                    end
                end
                StCntLo: begin
                    if (w_xfer) begin
                        r_count[7:0] <= rx_data;
                        r_word_idx   <= '0;
                        if (32'(w_count_next) > MAX_WORDS) begin
                            r_state    <= StError;
                            r_rx_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else if (w_count_next == '0) begin
                            r_state <= StCsum;
                        end else begin
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_word_done) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= 32'({r_word_idx, 2'b00});
                        r_imem_wdata <= w_word;
                        r_word_idx   <= r_word_idx + IDX_W'(1);
                        if (w_last_word) begin
                            r_state <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (w_xfer) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == w_csum) begin
                            r_state    <= StRun;
                            r_cpu_nrst <= 1'b1;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= StError;
                            r_err   <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    r_rx_ready <= 1'b0;
                end
                StError: begin
                    r_rx_ready <= 1'b0;
                end
                default: begin
                    // Unreachable encodings fail safe: hold the core in reset and flag an error.
                    r_state    <= StError;
                    r_rx_ready <= 1'b0;
                    r_cpu_nrst <= 1'b0;
                    r_err      <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_nrst   = r_cpu_nrst;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: frame table plus hand sequences, with a write scoreboard.
module tb_boot_loader;

    localparam int TB_MAX = 256;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_nrst;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    boot_loader #(.MAX_WORDS(TB_MAX)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_nrst   (cpu_nrst),
        .done       (done),
        .err        (err)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_writes = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        string        name;
        int           len;
        logic [191:0] bytes;  // right-justified, first byte most significant
        bit           gaps;
        bit           exp_done;
        bit           exp_err;
        int           exp_writes;
    } vec_t;
    vec_t vecs[7];

    // Reference frame model
    int          m_phase;
    int          m_widx;
    int          m_bidx;
    logic [15:0] m_n;
    logic [7:0]  m_csum;
    logic [31:0] m_word;
    bit          m_ended;
    bit          m_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write and last one cycle
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            chk_bit("we_one_cycle", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
        prev_we <= imem_we;
    end

    task automatic model_reset();
        m_phase = 0;
        m_widx  = 0;
        m_bidx  = 0;
        m_n     = '0;
        m_csum  = '0;
        m_word  = '0;
        m_ended = 0;
        m_ok    = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] d, output bit fin);
        wr_t e;
        fin = 0;
        case (m_phase)
            0: begin
                m_n[15:8] = d;
                m_phase = 1;
            end
            1: begin
                m_n[7:0] = d;
                if (int'(m_n) > TB_MAX) begin
                    m_ended = 1;
                    m_ok = 0;
                    fin = 1;
                end else if (m_n == 16'd0) begin
                    m_phase = 3;
                end else begin
                    m_phase = 2;
                    m_widx = 0;
                    m_bidx = 0;
                end
            end
            2: begin
                m_word = {m_word[23:0], d};
                m_csum = m_csum ^ d;
                m_bidx++;
                if (m_bidx == 4) begin
                    e.addr = 32'(m_widx * 4);
                    e.data = m_word;
                    exp_q.push_back(e);
                    m_widx++;
                    m_bidx = 0;
                    if (m_widx == int'(m_n)) m_phase = 3;
                end
            end
            default: begin
                m_ok = (d == m_csum);
                m_ended = 1;
                fin = 1;
            end
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        chk_bit({tag, "/rx_ready"}, rx_ready, 1'b1);
        chk_bit({tag, "/imem_we"}, imem_we, 1'b0);
        chk({tag, "/imem_addr"}, imem_addr, 32'h0);
        chk({tag, "/imem_wdata"}, imem_wdata, 32'h0);
        chk_bit({tag, "/cpu_nrst"}, cpu_nrst, 1'b0);
        chk_bit({tag, "/done"}, done, 1'b0);
        chk_bit({tag, "/err"}, err, 1'b0);
    endtask

    task automatic do_reset(input int cycles, input string tag);
        nrst = 1'b1;
        rx_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        nrst = 1'b0;
        model_reset();
        check_reset_state(tag);
    endtask

    // Drive one byte (optionally after idle cycles); checks the terminal outputs right after
    // the edge that ends the frame.
    task automatic send_byte(input logic [7:0] d, input bit gaps);
        bit fin;
        int idle;
        if (gaps) begin
            idle = int'($urandom_range(2, 0));
            repeat (idle) begin
                rx_valid = 1'b0;
                rx_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data = d;
        fin = 0;
        if (!m_ended) model_byte(d, fin);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (fin) begin
            chk_bit("term/done", done, m_ok);
            chk_bit("term/cpu_nrst", cpu_nrst, m_ok);
            chk_bit("term/err", err, !m_ok);
            chk_bit("term/rx_ready", rx_ready, 1'b0);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit with_reset);
        int w0;
        if (with_reset) do_reset(2, {v.name, "/reset"});
        w0 = n_writes;
        for (int i = 0; i < v.len; i++) send_byte(v.bytes[8*(v.len-1-i) +: 8], v.gaps);
        repeat (3) @(posedge clk);
        #1;
        chk_bit({v.name, "/done"}, done, v.exp_done);
        chk_bit({v.name, "/err"}, err, v.exp_err);
        chk_bit({v.name, "/cpu_nrst"}, cpu_nrst, v.exp_done);
        chk_bit({v.name, "/rx_ready"}, rx_ready, 1'b0);
        chk({v.name, "/writes"}, 32'(n_writes - w0), 32'(v.exp_writes));
        chk({v.name, "/sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic vec_t mk(input string name, input int len, input logic [191:0] b,
                                input bit gaps, input bit ed, input bit ee, input int nw);
        vec_t v;
        v.name = name;
        v.len = len;
        v.bytes = b;
        v.gaps = gaps;
        v.exp_done = ed;
        v.exp_err = ee;
        v.exp_writes = nw;
        return v;
    endfunction

    initial begin
        int w0;
        logic [31:0] w;

        vecs[0] = mk("single", 7, 192'({8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D}),
                     0, 1, 0, 1);
        vecs[1] = mk("three_gaps", 15, 192'({8'h00, 8'h03, 32'h11111111, 32'h22222222,
                     32'h33333333, 8'h00}), 1, 1, 0, 3);
        vecs[2] = mk("bad_csum", 9, 192'({8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C,
                     8'hAA, 8'h55}), 0, 0, 1, 1);
        vecs[3] = mk("oversize", 4, 192'({8'h01, 8'h01, 8'h00, 8'h00}), 0, 0, 1, 0);
        vecs[4] = mk("empty", 3, 192'({8'h00, 8'h00, 8'h00}), 0, 1, 0, 0);
        vecs[5] = mk("empty_bad", 3, 192'({8'h00, 8'h00, 8'h01}), 0, 0, 1, 0);
        vecs[6] = mk("run_ignore", 9, 192'({8'h00, 8'h01, 32'hDEADBEEF, 8'h22, 8'h12, 8'h34}),
                     1, 1, 0, 1);

        do_reset(3, "por");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1);

        // Reset mid-word discards the partial word, then a full frame loads from address 0.
        do_reset(2, "midword/pre");
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset(1, "midword");
        repeat (4) @(posedge clk);
        #1;
        chk_bit("midword/no_write", imem_we, 1'b0);
        run_vec(vecs[0], 0);

        // Reset while running re-holds the core in reset.
        do_reset(1, "reset_in_run");

        // Largest accepted image: N == MAX_WORDS.
        do_reset(2, "max/reset");
        w0 = n_writes;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        chk_bit("max/err_after_hdr", err, 1'b0);
        chk_bit("max/rx_ready_after_hdr", rx_ready, 1'b1);
        for (int i = 0; i < TB_MAX; i++) begin
            w = {8'(i), 8'(i) ^ 8'h5A, 8'hC3, ~8'(i)};
            for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], 0);
        end
        send_byte(m_csum, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_bit("max/done", done, 1'b1);
        chk("max/writes", 32'(n_writes - w0), 32'(TB_MAX));
        chk("max/last_addr", imem_addr, 32'h0000_03FC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-serial program loader that sits directly upstream of the MIPS core. It receives a framed program image over a valid/ready byte stream and assembles big-endian 32-bit words. Each word is written into instruction memory through a write port. While loading, the core is held in reset; after a verified checksum the core is released to execute from address 0.

## Interface
Parameters:
- MAX_WORDS, 256, capacity of instruction memory in 32-bit words; larger images are rejected.
- CNT_WIDTH, 16, width of the word-count header field; fixed framing, not to be overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  synchronous, active-high reset.
- rx_valid  in  1  upstream byte valid.
- rx_data  in  8  upstream byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at a clock edge.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  32  byte address of the write, always word-aligned (bits [1:0] = 0).
- imem_wdata  out  32  word to write.
- cpu_nrst  out  1  reset to MIPS core; 0 holds the core in reset, 1 releases it.
- done  out  1  image loaded and verified; core running.
- err  out  1  sticky framing or checksum error.

## Operation
- Frame format: count high byte, count low byte (N, big-endian), then 4·N data bytes (each word big-endian, MSB first), then 1 checksum byte.
- Checksum = XOR of the 4·N data bytes only. Count bytes are excluded. When N = 0, the expected checksum is 0x00.
- FSM states: CNT_HI, CNT_LO, DATA, CSUM, RUN, ERROR.
- CNT_HI: accept byte → count[15:8]; go to CNT_LO.
- CNT_LO: accept byte → count[7:0].
  - If N > MAX_WORDS: go to ERROR.
  - Else if N == 0: go to CSUM.
  - Else: go to DATA, with word_idx = 0 and byte_idx = 0.
- DATA: each accepted byte shifts into the word register (word = {word[23:0], rx_data}) and XORs into the checksum accumulator.
  - On the 4th byte (byte_idx == 3): issue the write; word_idx++; byte_idx → 0.
  - After the write for word N−1: go to CSUM.
- CSUM:
  - Accepted byte == accumulator: go to RUN.
  - Otherwise: go to ERROR.
- RUN: rx_ready = 0, cpu_nrst = 1, done = 1. Terminal until nrst.
- ERROR: rx_ready = 0, cpu_nrst = 0, err = 1. Terminal until nrst.
- rx_ready = 1 in CNT_HI, CNT_LO, DATA and CSUM. The loader never back-pressures mid-frame.
- Bytes presented with rx_valid in RUN or ERROR are not consumed and are ignored.
- word_idx width = clog2(MAX_WORDS + 1). imem_addr = {word_idx, 2'b00}, zero-extended to 32 bits.

## Timing
- Reset values: state = CNT_HI, rx_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_nrst = 0, done = 0, err = 0. Accumulator, counters and count are cleared.
- imem_we pulses high exactly 1 cycle: the cycle after the handshake of a word's 4th byte.
  - imem_addr and imem_wdata are valid in that same cycle.
  - They hold their values until the next write.
- Back-to-back bytes on consecutive cycles are legal. At full rate, writes occur every 4 cycles with no overlap.
- Checksum byte accepted at edge T: done and cpu_nrst rise in the cycle after T (registered), or err rises in that cycle.
- Oversize count accepted at edge T: err = 1 in the cycle after T. No writes are issued.
- nrst asserted in any state, including mid-word and in RUN: all outputs return to their reset values at the next edge. This re-holds the core in reset. A partially assembled word is discarded and no write is issued for it. IMEM contents are not cleared.
- rx_valid with no rx_ready, or rx_ready with no rx_valid: no state change.

## Structure
- Shared header boot_defs.vh holds:
  - state encodings (3-bit localparams);
  - CNT_WIDTH;
  - the word size in bytes (4).
- One sub-module, word_assembler, handles assembly and checksum:
  - 32-bit shift register;
  - 2-bit byte counter;
  - XOR accumulator;
  - a word_done pulse.
- Top-level boot_loader holds the FSM, word_idx, the write-port registers and cpu_nrst.

## Test plan
- Single instruction, at full rate: stream 00 01 20 08 00 05 2D → one imem_we with addr 0x0, wdata 0x20080005; then cpu_nrst = 1, done = 1, err = 0.
- Three words with idle gaps (rx_valid toggling): data 0x11111111, 0x22222222, 0x33333333, checksum 0x00.
  - Writes go to 0x0, 0x4 and 0x8 in order.
  - Each imem_we is 1 cycle wide.
  - done = 1.
- Bad checksum: the first frame with the last byte 0x2C → one write, then err = 1, cpu_nrst stays 0. Further bytes are ignored (rx_ready = 0).
- Oversize with MAX_WORDS = 256: header 01 01 → err = 1 the cycle after the 2nd byte; imem_we never asserted.
- Empty image: 00 00 00 → no writes, done = 1. Empty image with trailer 00 00 01 → err = 1.
- Reset mid-word:
  - Send 00 02 AA BB, then assert nrst for 1 cycle → outputs at reset values, no write.
  - Then resend a full single-word frame → load succeeds with addr 0x0.
